// File: rtl/adc_pipe_pkg.sv
// ----------------------------------------------------------------------------
// adc_pipe_pkg
// Shared definitions for the pipelined-ADC stage sequencer:
//   - seq_state_t : sequencer FSM state encoding
//   - CODE_*      : the three legal one-hot comparator codes
//   - *_DEF       : default dwell lengths for the switch phases and gaps
//   - code_legal(): true when a 3-bit comparator code is one of the legal codes
// ----------------------------------------------------------------------------
package adc_pipe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PH1   = 3'd1,
        ST_GAP1  = 3'd2,
        ST_PH2   = 3'd3,
        ST_GAP2  = 3'd4,
        ST_FLUSH = 3'd5
    } seq_state_t;

    localparam logic [2:0] CODE_LO  = 3'b001;
    localparam logic [2:0] CODE_MID = 3'b010;
    localparam logic [2:0] CODE_HI  = 3'b100;

    localparam int PHASE_CYCLES_DEF = 2;
    localparam int NONOV_CYCLES_DEF = 1;

    function automatic logic code_legal(input logic [2:0] code);
        return (code == CODE_LO) || (code == CODE_MID) || (code == CODE_HI);
    endfunction

endpackage

// File: rtl/adc_pipe_phase_gen.sv
// ----------------------------------------------------------------------------
// adc_pipe_phase_gen
// Dwell counter for the sequencer. The FSM tells it what the next state is
// (active or not, switch phase or non-overlap gap); it answers with a
// registered flag marking the last cycle of the current state and a
// registered latch strobe on the last cycle of every switch phase.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset
//   idle         in   current FSM state is IDLE (holds the counter at zero)
//   next_active  in   next FSM state is not IDLE
//   next_phase   in   next FSM state drives a switch phase (PH1/PH2/flush PH1)
//   last         out  current cycle is the last one of the current state
//   latch        out  comparator latch strobe (last cycle of a switch phase)
// ----------------------------------------------------------------------------
module adc_pipe_phase_gen #(
    parameter int PHASE_CYCLES = 2,
    parameter int NONOV_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic idle,
    input  logic next_active,
    input  logic next_phase,
    output logic last,
    output logic latch
);

    localparam logic [3:0] PHASE_M1 = 4'(PHASE_CYCLES - 1);
    localparam logic [3:0] NONOV_M1 = 4'(NONOV_CYCLES - 1);

    logic [3:0] cnt_r;
    logic [3:0] cnt_next_s;
    logic [3:0] dwell_m1_s;
    logic       last_r;
    logic       latch_r;
    logic       last_next_s;

    // Next dwell count: every state change happens on a last cycle, so the
    // counter restarts there (or while idle) and otherwise counts up.
    always_comb begin
        cnt_next_s  = 4'd0;
        dwell_m1_s  = 4'd0;
        last_next_s = 1'b0;
        if (idle || last_r) begin
            cnt_next_s = 4'd0;
        end else begin
            cnt_next_s = cnt_r + 4'd1;
        end
        if (next_phase) begin
            dwell_m1_s = PHASE_M1;
        end else begin
            dwell_m1_s = NONOV_M1;
        end
        last_next_s = (cnt_next_s == dwell_m1_s);
    end

    // Dwell counter plus registered last-cycle and latch flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r   <= 4'd0;
            last_r  <= 1'b0;
            latch_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            last_r  <= last_next_s && next_active;
            latch_r <= last_next_s && next_active && next_phase;
        end
    end

    assign last  = last_r;
    assign latch = latch_r;

endmodule

// File: rtl/adc_pipe_sequencer.sv
// ----------------------------------------------------------------------------
// adc_pipe_sequencer
// Sequences a three-stage pipelined ADC: generates non-overlapping switch
// phases phi1/phi2 with gaps, strobes the comparator latch, captures the
// stage codes at the end of the matching gaps and re-aligns them so one
// sample's three codes appear together with a valid strobe.
//
// Period: PH1 -> GAP1 -> PH2 -> GAP2. Stage-1 code captured at end of GAP1,
// stage-2 at end of GAP2, stage-3 at end of the following GAP1. At run end
// the period finishes, then FLUSH (one PH1 + GAP1) completes the last sample.
//
// Build option: define ADC_PIPE_SEQ_BURST_EN to enable burst_len_i and the
// saturating sample counter; without it every run is continuous until stop_i.
//
// Ports:
//   clock_i      in   clock (rising edge)
//   reset_i      in   synchronous active-high reset
//   start_i      in   start request, honoured only in IDLE
//   stop_i       in   stop request, finishes current sample then flushes
//   burst_len_i  in   [7:0] samples per run, 0 = continuous (sampled at start)
//   d1_i/d2_i    in   [2:0] stage-1 / stage-2 one-hot comparator codes
//   d3_i         in   stage-3 comparator bit
//   phi1_o/phi2_o out non-overlapping switch phases
//   latch_o      out  comparator latch strobe
//   d1_o/d2_o/d3_o out time-aligned codes of one sample
//   valid_o      out  one-cycle strobe qualifying d1_o/d2_o/d3_o
//   busy_o       out  run active
//   done_o       out  end-of-run pulse, coincident with the final valid_o
//   err_o        out  sticky illegal-code flag, cleared on accepted start
// ----------------------------------------------------------------------------
module adc_pipe_sequencer
    import adc_pipe_pkg::*;
#(
    parameter int PHASE_CYCLES = PHASE_CYCLES_DEF,
    parameter int NONOV_CYCLES = NONOV_CYCLES_DEF
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic [7:0] burst_len_i,
    input  logic [2:0] d1_i,
    input  logic [2:0] d2_i,
    input  logic       d3_i,
    output logic       phi1_o,
    output logic       phi2_o,
    output logic       latch_o,
    output logic [2:0] d1_o,
    output logic [2:0] d2_o,
    output logic       d3_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    seq_state_t state_r;
    seq_state_t state_next_s;
    logic       flush_gap_r;
    logic       flush_gap_next_s;
    logic       stop_req_r;

    logic       last_s;
    logic       latch_s;
    logic       idle_s;
    logic       start_acc_s;
    logic       end_run_s;
    logic       burst_hit_s;
    logic       complete_s;
    logic       next_active_s;
    logic       next_phase_s;

    logic [2:0] d1_hold_r;
    logic [2:0] d2_hold_r;
    logic       pend_r;

    logic [2:0] d1_r;
    logic [2:0] d2_r;
    logic       d3_r;
    logic       valid_r;
    logic       done_r;
    logic       err_r;
    logic       busy_r;
    logic       phi1_r;
    logic       phi2_r;

    assign idle_s      = (state_r == ST_IDLE);
    assign start_acc_s = idle_s && start_i;

`ifdef ADC_PIPE_SEQ_BURST_EN
    logic [7:0] burst_r;
    logic [7:0] smp_cnt_r;

    // Burst length is latched at start; the sample counter counts finished
    // periods and saturates so continuous runs never wrap.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            burst_r   <= 8'd0;
            smp_cnt_r <= 8'd0;
        end else if (start_acc_s) begin
            burst_r   <= burst_len_i;
            smp_cnt_r <= 8'd0;
        end else if ((state_r == ST_GAP2) && last_s && (smp_cnt_r != 8'hFF)) begin
            smp_cnt_r <= smp_cnt_r + 8'd1;
        end else begin
            smp_cnt_r <= smp_cnt_r;
        end
    end

    // The period ending now is the last one when it brings the count to burst.
    assign burst_hit_s = (burst_r != 8'd0) &&
                         (({1'b0, smp_cnt_r} + 9'd1) == {1'b0, burst_r});
`else
    logic unused_burst_s;
    assign unused_burst_s = ^burst_len_i;
    assign burst_hit_s    = 1'b0;
`endif

    assign end_run_s = stop_i || stop_req_r || burst_hit_s;

    // Next-state logic. FLUSH has two halves (switch phase, then gap)
    // tracked by flush_gap.
    always_comb begin
        state_next_s     = state_r;
        flush_gap_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_next_s = ST_PH1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PH1: begin
                if (last_s) begin
                    state_next_s = ST_GAP1;
                end else begin
                    state_next_s = ST_PH1;
                end
            end
            ST_GAP1: begin
                if (last_s) begin
                    state_next_s = ST_PH2;
                end else begin
                    state_next_s = ST_GAP1;
                end
            end
            ST_PH2: begin
                if (last_s) begin
                    state_next_s = ST_GAP2;
                end else begin
                    state_next_s = ST_PH2;
                end
            end
            ST_GAP2: begin
                if (last_s) begin
                    if (end_run_s) begin
                        state_next_s = ST_FLUSH;
                    end else begin
                        state_next_s = ST_PH1;
                    end
                end else begin
                    state_next_s = ST_GAP2;
                end
            end
            ST_FLUSH: begin
                if (last_s) begin
                    if (flush_gap_r) begin
                        state_next_s     = ST_IDLE;
                        flush_gap_next_s = 1'b0;
                    end else begin
                        state_next_s     = ST_FLUSH;
                        flush_gap_next_s = 1'b1;
                    end
                end else begin
                    state_next_s     = ST_FLUSH;
                    flush_gap_next_s = flush_gap_r;
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                flush_gap_next_s = 1'b0;
            end
        endcase
    end

    // Decode of the next state, used to register the phase outputs so they
    // line up exactly with the state they belong to.
    always_comb begin
        next_active_s = 1'b0;
        next_phase_s  = 1'b0;
        if (state_next_s != ST_IDLE) begin
            next_active_s = 1'b1;
        end else begin
            next_active_s = 1'b0;
        end
        if ((state_next_s == ST_PH1) || (state_next_s == ST_PH2) ||
            ((state_next_s == ST_FLUSH) && !flush_gap_next_s)) begin
            next_phase_s = 1'b1;
        end else begin
            next_phase_s = 1'b0;
        end
    end

    // A sample completes when its stage-3 bit is captured: end of the next
    // period's GAP1, or end of the FLUSH gap for the final sample.
    assign complete_s = last_s &&
                        (((state_r == ST_GAP1) && pend_r) ||
                         ((state_r == ST_FLUSH) && flush_gap_r));

    adc_pipe_phase_gen #(
        .PHASE_CYCLES (PHASE_CYCLES),
        .NONOV_CYCLES (NONOV_CYCLES)
    ) u_phase_gen (
        .clock       (clock_i),
        .reset       (reset_i),
        .idle        (idle_s),
        .next_active (next_active_s),
        .next_phase  (next_phase_s),
        .last        (last_s),
        .latch       (latch_s)
    );

    // FSM state, flush half and registered phase/busy outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r     <= ST_IDLE;
            flush_gap_r <= 1'b0;
            phi1_r      <= 1'b0;
            phi2_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            flush_gap_r <= flush_gap_next_s;
            phi1_r      <= (state_next_s == ST_PH1) ||
                           ((state_next_s == ST_FLUSH) && !flush_gap_next_s);
            phi2_r      <= (state_next_s == ST_PH2);
            busy_r      <= next_active_s;
        end
    end

    // Pending stop: remembered until the period ends; ignored in IDLE and
    // once flushing has started.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stop_req_r <= 1'b0;
        end else if (idle_s) begin
            stop_req_r <= 1'b0;
        end else if (stop_i && (state_r != ST_FLUSH)) begin
            stop_req_r <= 1'b1;
        end else begin
            stop_req_r <= stop_req_r;
        end
    end

    // Code capture, sample alignment, valid/done strobes and sticky error.
    // Illegal codes are still forwarded raw.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            d1_hold_r <= 3'd0;
            d2_hold_r <= 3'd0;
            pend_r    <= 1'b0;
            d1_r      <= 3'd0;
            d2_r      <= 3'd0;
            d3_r      <= 1'b0;
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            if ((state_r == ST_GAP1) && last_s) begin
                d1_hold_r <= d1_i;
            end
            if ((state_r == ST_GAP2) && last_s) begin
                d2_hold_r <= d2_i;
                pend_r    <= 1'b1;
            end else if (complete_s) begin
                pend_r    <= 1'b0;
            end
            if (complete_s) begin
                d1_r <= d1_hold_r;
                d2_r <= d2_hold_r;
                d3_r <= d3_i;
            end
            valid_r <= complete_s;
            done_r  <= complete_s && (state_r == ST_FLUSH);
            if (start_acc_s) begin
                err_r <= 1'b0;
            end else if (complete_s &&
                         (!code_legal(d1_hold_r) || !code_legal(d2_hold_r))) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign phi1_o  = phi1_r;
    assign phi2_o  = phi2_r;
    assign latch_o = latch_s;
    assign d1_o    = d1_r;
    assign d2_o    = d2_r;
    assign d3_o    = d3_r;
    assign valid_o = valid_r;
    assign busy_o  = busy_r;
    assign done_o  = done_r;
    assign err_o   = err_r;

endmodule

// File: tb/tb_adc_pipe_sequencer.sv
// ----------------------------------------------------------------------------
// tb_adc_pipe_sequencer
// Self-checking bench for adc_pipe_sequencer with default parameters.
// Expected samples are pushed to a scoreboard queue at the cycle their
// stage-3 bit is driven and popped when valid_o is seen. Phase, latch, busy,
// valid, done and error outputs are compared every cycle against a timing
// model derived from the 6-cycle period.
// ----------------------------------------------------------------------------
module tb_adc_pipe_sequencer;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic       stop_i;
    logic [7:0] burst_len_i;
    logic [2:0] d1_i;
    logic [2:0] d2_i;
    logic       d3_i;
    logic       phi1_o;
    logic       phi2_o;
    logic       latch_o;
    logic [2:0] d1_o;
    logic [2:0] d2_o;
    logic       d3_o;
    logic       valid_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    typedef struct {
        logic [2:0] d1;
        logic [2:0] d2;
        logic       d3;
    } smp_t;

    smp_t       sb_q[$];
    logic [2:0] d1_hist [0:63];
    logic [2:0] d2_hist [0:63];
    logic [2:0] exp_d1 = 3'd0;
    logic [2:0] exp_d2 = 3'd0;
    logic       exp_d3 = 1'b0;
    logic       exp_err = 1'b0;

    int check_cnt = 0;
    int error_cnt = 0;

    adc_pipe_sequencer u_dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .burst_len_i (burst_len_i),
        .d1_i        (d1_i),
        .d2_i        (d2_i),
        .d3_i        (d3_i),
        .phi1_o      (phi1_o),
        .phi2_o      (phi2_o),
        .latch_o     (latch_o),
        .d1_o        (d1_o),
        .d2_o        (d2_o),
        .d3_o        (d3_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] rand_code();
        logic [2:0] v;
        v = 3'b001;
        return v << $urandom_range(0, 2);
    endfunction

    function automatic logic is_onehot(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    // One run starting at cycle 0 (start_i high). stop_cyc < 1 means no
    // stop; rst_cyc >= 0 pulses reset_i in that cycle and aborts the run.
    task automatic run_seq(input string name, input int burst, input int stop_cyc,
                           input int bad_smp, input int rst_cyc, input bit const_data);
        int   k;
        int   e;
        int   last_c;
        smp_t s;
        k = 1000;
`ifdef ADC_PIPE_SEQ_BURST_EN
        if (burst > 0) k = burst;
`endif
        if (stop_cyc >= 1) begin
            if (((stop_cyc - 1) / 6 + 1) < k) k = (stop_cyc - 1) / 6 + 1;
        end
        e      = 6 * k + 4;
        last_c = (rst_cyc >= 0) ? rst_cyc + 2 : e + 2;
        burst_len_i = 8'(burst);
        for (int c = 0; c <= last_c; c++) begin
            int p;
            int rel;
            bit aborted;
            bit in_run;
            bit exp_valid;
            p       = (c - 1) / 6;
            rel     = (c - 1) % 6;
            aborted = (rst_cyc >= 0) && (c > rst_cyc);
            // stop at cycle 0 (IDLE) and inside FLUSH must be ignored;
            // start at cycle 5 (busy) must be ignored.
            start_i = (c == 0) || (c == 5);
            stop_i  = (c == 0) || (c == stop_cyc) || (c == e - 2);
            reset_i = (c == rst_cyc);
            if (const_data) begin
                d1_i = 3'b100;
                d2_i = 3'b001;
                d3_i = 1'b1;
            end else begin
                d1_i = rand_code();
                d2_i = rand_code();
                d3_i = 1'($urandom_range(0, 1));
            end
            if ((c >= 1) && (rel == 5) && (p == bad_smp)) d2_i = 3'b011;
            if ((c >= 1) && ((rst_cyc < 0) || (c < rst_cyc)) && (p < 64)) begin
                if ((rel == 2) && (p < k)) d1_hist[p] = d1_i;
                if ((rel == 5) && (p < k)) d2_hist[p] = d2_i;
                if ((rel == 2) && (p >= 1) && (p <= k)) begin
                    s.d1 = d1_hist[p-1];
                    s.d2 = d2_hist[p-1];
                    s.d3 = d3_i;
                    sb_q.push_back(s);
                end
            end

            @(negedge clock_i);
            in_run    = (c >= 1) && (c < e) && !aborted;
            exp_valid = (c >= 1) && (rel == 3) && (p >= 1) && (p <= k) && !aborted;
            if ((c == 1) && !aborted) exp_err = 1'b0;
            if (aborted) begin
                exp_d1  = 3'd0;
                exp_d2  = 3'd0;
                exp_d3  = 1'b0;
                exp_err = 1'b0;
            end
            check_val($sformatf("%s.c%0d.valid", name, c), 32'(valid_o), 32'(exp_valid));
            if (valid_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_val($sformatf("%s.c%0d.sb_underflow", name, c), 32'd0, 32'd1);
                end else begin
                    s = sb_q.pop_front();
                    exp_d1 = s.d1;
                    exp_d2 = s.d2;
                    exp_d3 = s.d3;
                    if (!is_onehot(s.d1) || !is_onehot(s.d2)) exp_err = 1'b1;
                end
            end
            check_val($sformatf("%s.c%0d.d1", name, c), 32'(d1_o), 32'(exp_d1));
            check_val($sformatf("%s.c%0d.d2", name, c), 32'(d2_o), 32'(exp_d2));
            check_val($sformatf("%s.c%0d.d3", name, c), 32'(d3_o), 32'(exp_d3));
            check_val($sformatf("%s.c%0d.err", name, c), 32'(err_o), 32'(exp_err));
            check_val($sformatf("%s.c%0d.busy", name, c), 32'(busy_o), 32'(in_run));
            check_val($sformatf("%s.c%0d.phi1", name, c), 32'(phi1_o),
                      32'(in_run && (rel < 2)));
            check_val($sformatf("%s.c%0d.phi2", name, c), 32'(phi2_o),
                      32'(in_run && (p < k) && ((rel == 3) || (rel == 4))));
            check_val($sformatf("%s.c%0d.latch", name, c), 32'(latch_o),
                      32'(in_run && ((rel == 1) || ((p < k) && (rel == 4)))));
            check_val($sformatf("%s.c%0d.done", name, c), 32'(done_o),
                      32'((c == e) && !aborted));
            check_val($sformatf("%s.c%0d.overlap", name, c), 32'(phi1_o && phi2_o), 32'd0);
            @(posedge clock_i);
            #1;
        end
        start_i = 1'b0;
        stop_i  = 1'b0;
        reset_i = 1'b0;
        check_val($sformatf("%s.sb_empty", name), 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        reset_i     = 1'b1;
        start_i     = 1'b0;
        stop_i      = 1'b0;
        burst_len_i = 8'd0;
        d1_i        = 3'b001;
        d2_i        = 3'b001;
        d3_i        = 1'b0;
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        check_val("rst.phi1",  32'(phi1_o),  32'd0);
        check_val("rst.phi2",  32'(phi2_o),  32'd0);
        check_val("rst.latch", 32'(latch_o), 32'd0);
        check_val("rst.valid", 32'(valid_o), 32'd0);
        check_val("rst.busy",  32'(busy_o),  32'd0);
        check_val("rst.done",  32'(done_o),  32'd0);
        check_val("rst.err",   32'(err_o),   32'd0);
        check_val("rst.data",  32'({d1_o, d2_o, d3_o}), 32'd0);
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        @(posedge clock_i);
        #1;

`ifdef ADC_PIPE_SEQ_BURST_EN
        run_seq("burst2", 2, -1, -1, -1, 1'b0);
`else
        run_seq("burst2", 2, 8, -1, -1, 1'b0);
`endif
        run_seq("cont_const", 0, 20, -1, -1, 1'b1);
        run_seq("bad_code", 0, 26, 1, -1, 1'b0);
        run_seq("clear_err", 0, 8, -1, -1, 1'b0);
        run_seq("reset_mid", 0, -1, -1, 8, 1'b0);
`ifdef ADC_PIPE_SEQ_BURST_EN
        run_seq("after_rst", 3, -1, -1, -1, 1'b0);
`else
        run_seq("after_rst", 3, 14, -1, -1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
